// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with fill level, almost flags, FWFT option and sticky errors
// Status flags derive only from the registered level; pointers carry a wrap bit beyond the address.
module sync_fifo_ctrl #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rout,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic [ASIZE:0]   level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int             DEPTH    = 2**ASIZE;
  localparam logic [ASIZE:0] FULL_LVL = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_LVL   = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AE_LVL   = (ASIZE+1)'(AEMPTY_LVL);
  localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [ASIZE-1:0] waddr, raddr;
  logic             wr_en, rd_en;

  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  assign wfull        = (level_q == FULL_LVL);
  assign rempty       = (level_q == '0);
  assign level        = level_q;
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Acceptance uses registered flags only, so a same-cycle pop never frees a full slot.
  assign wr_en = win && !wfull;
  assign rd_en = rout && !rempty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_en) wptr_d = wptr_q + ONE;
    if (rd_en) rptr_d = rptr_q + ONE;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
    ovf_d = (win && wfull) || (ovf_q && !clr_err);
    udf_d = (rout && rempty) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Forced to zero while empty so the output matches the cleared register mode after reset.
      assign rdata = rempty ? '0 : mem_q[raddr];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (rd_en) rdata_d = mem_q[raddr];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - randomized queue-model bench for both read modes of sync_fifo_ctrl
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       win, rout, clr_err;
  logic [7:0] wdata;

  logic       wfull0, rempty0, af0, ae0, ovf0, udf0;
  logic [7:0] rdata0;
  logic [4:0] level0;
  logic       wfull1, rempty1, af1, ae1, ovf1, udf1;
  logic [7:0] rdata1;
  logic [4:0] level1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic       ovf_m, udf_m;
  logic [7:0] rd_m;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .win(win), .wdata(wdata), .wfull(wfull0),
    .rout(rout), .rdata(rdata0), .rempty(rempty0), .level(level0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0),
    .underflow(udf0), .clr_err(clr_err)
  );

  sync_fifo_ctrl #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .win(win), .wdata(wdata), .wfull(wfull1),
    .rout(rout), .rdata(rdata1), .rempty(rempty1), .level(level1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1),
    .underflow(udf1), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int  n;
    logic ptr_full, ptr_empty;
    n = q.size();
    check("level0",  32'(level0),  n);
    check("level1",  32'(level1),  n);
    check("wfull0",  32'(wfull0),  32'(n == 16));
    check("wfull1",  32'(wfull1),  32'(n == 16));
    check("rempty0", 32'(rempty0), 32'(n == 0));
    check("rempty1", 32'(rempty1), 32'(n == 0));
    check("afull0",  32'(af0),     32'(n >= 12));
    check("afull1",  32'(af1),     32'(n >= 12));
    check("aempty0", 32'(ae0),     32'(n <= 2));
    check("aempty1", 32'(ae1),     32'(n <= 2));
    check("ovf0",    32'(ovf0),    32'(ovf_m));
    check("ovf1",    32'(ovf1),    32'(ovf_m));
    check("udf0",    32'(udf0),    32'(udf_m));
    check("udf1",    32'(udf1),    32'(udf_m));
    check("rdata0",  32'(rdata0),  32'(rd_m));
    check("rdata1",  32'(rdata1),  (n != 0) ? 32'(q[0]) : 32'h0);
    ptr_full  = (u_reg.wptr_q[4] != u_reg.rptr_q[4]) && (u_reg.wptr_q[3:0] == u_reg.rptr_q[3:0]);
    ptr_empty = (u_reg.wptr_q == u_reg.rptr_q);
    check("ptr_full",  32'(ptr_full),  32'(n == 16));
    check("ptr_empty", 32'(ptr_empty), 32'(n == 0));
  endtask

  // One clock of stimulus; the model decides acceptance from its pre-edge occupancy.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic full, empty, wacc, racc;
    win = w; wdata = d; rout = r; clr_err = c;
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    wacc  = w && !full;
    racc  = r && !empty;
    ovf_m = (w && full)  || (ovf_m && !c);
    udf_m = (r && empty) || (udf_m && !c);
    @(posedge clk);
    #1;
    if (racc) begin
      rd_m = q[0];
      void'(q.pop_front());
    end
    if (wacc) q.push_back(d);
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    rd_m  = 8'h00;
  endtask

  initial begin
    rst = 1'b1; win = 1'b0; rout = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Fill with 0x01..0x10, then overflow with 0xAA and clear.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hAB, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Drain in order, then underflow and clear.
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Fall-through on first write to empty.
    cycle(1'b1, 8'h5C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Steady level 8 with simultaneous push/pop across several wraps.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);

    // Full with simultaneous read: write blocked, read accepted.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic, write-biased then read-biased to hit both boundaries.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      cycle(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < (100 - wp)),
            ($urandom_range(0, 99) < 5));
    end

    // Asynchronous reset with level 9 mid-burst.
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    win = 1'b1; wdata = 8'h77;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    win = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_outputs();
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_rdata", 32'(rdata0), 32'h33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
